// File: rtl/trng_pkg.sv
// Shared constants and helpers for the TRNG von Neumann packer and its output buffer.
package trng_pkg;
  localparam logic MODE_VN     = 1'b0;
  localparam logic MODE_BYPASS = 1'b1;

  localparam int DEF_WORD_W     = 8;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int DEF_RCT_CUTOFF = 32;

  // Bits needed to hold an occupancy of 0..depth inclusive.
  function automatic int occ_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/trng_vn_packer_if.sv
// Output word stream of the packer: o_word/o_valid from producer, i_ready from consumer.
// A word transfers on a clock edge with o_valid=1 and i_ready=1; while o_valid=1 and
// i_ready=0 the producer holds o_word and o_valid stable; i_ready is ignored when o_valid=0.
interface trng_vn_packer_if
  import trng_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W
);
  logic [WORD_W-1:0] o_word;
  logic              o_valid;
  logic              i_ready;

  modport master (output o_word, output o_valid, input i_ready);
  modport slave  (input o_word, input o_valid, output i_ready);
endinterface

// File: rtl/trng_sync_fifo.sv
// Single-clock word FIFO with push/pop/full/empty/count; head word reads 0 when empty.
module trng_sync_fifo
  import trng_pkg::*;
#(
  parameter int W     = DEF_WORD_W,
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic [W-1:0]             i_data,
  input  logic                     i_pop,
  output logic [W-1:0]             o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [occ_w(DEPTH)-1:0]  o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = occ_w(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic          pop_ok;
  logic          push_ok;

  assign o_empty = (count_q == '0);
  assign o_full  = (count_q == CW'(DEPTH));
  assign o_count = count_q;
  assign o_data  = o_empty ? '0 : mem[rd_ptr];

  // A push into a full buffer still succeeds when the head leaves on the same edge.
  assign pop_ok  = i_pop & ~o_empty;
  assign push_ok = i_push & (~o_full | pop_ok);

  always_ff @(posedge i_clk) begin
    if (push_ok) mem[wr_ptr] <= i_data;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: rtl/trng_vn_packer.sv
// Raw entropy bits -> optional von Neumann debias -> LSB-first word packing -> output FIFO,
// with a repetition-count health test that halts sampling until software clears the alarm.
module trng_vn_packer
  import trng_pkg::*;
#(
  parameter int WORD_W     = DEF_WORD_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int RCT_CUTOFF = DEF_RCT_CUTOFF
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_en,
  input  logic                          i_mode,
  input  logic                          i_bit,
  input  logic                          i_bit_valid,
  input  logic                          i_alarm_clr,
  trng_vn_packer_if.master              out_if,
  output logic [occ_w(FIFO_DEPTH)-1:0]  o_count,
  output logic                          o_overflow,
  output logic                          o_alarm
);
  localparam int IDX_W = $clog2(WORD_W);
  localparam int RUN_W = $clog2(RCT_CUTOFF + 1);

  logic              mode_q;
  logic              pair_have_q;
  logic              pair_bit_q;
  logic [WORD_W-1:0] word_q;
  logic [IDX_W-1:0]  idx_q;
  logic [RUN_W-1:0]  run_q;
  logic              last_q;

  logic              sample;
  logic              emit;
  logic              emit_bit;
  logic [RUN_W-1:0]  run_nxt;
  logic              rct_hit;
  logic              word_done;
  logic [WORD_W-1:0] push_word;
  logic              fifo_full;
  logic              fifo_empty;
  logic              ovf_set;

  assign sample = i_en & i_bit_valid & ~o_alarm;

  always_comb begin
    emit      = 1'b0;
    emit_bit  = 1'b0;
    run_nxt   = run_q;
    if (sample) begin
      if (mode_q == MODE_BYPASS) begin
        emit     = 1'b1;
        emit_bit = i_bit;
      end else if (pair_have_q && (pair_bit_q != i_bit)) begin
        // 01 -> 0, 10 -> 1: the first half of a mismatched pair is the output bit.
        emit     = 1'b1;
        emit_bit = pair_bit_q;
      end
      if ((run_q == '0) || (i_bit != last_q))  run_nxt = RUN_W'(1);
      else if (run_q != RUN_W'(RCT_CUTOFF))    run_nxt = run_q + RUN_W'(1);
    end
    rct_hit   = sample & ~i_alarm_clr & (run_nxt == RUN_W'(RCT_CUTOFF));
    word_done = emit & ~rct_hit & (idx_q == IDX_W'(WORD_W - 1));
    push_word = word_q;
    push_word[WORD_W-1] = emit_bit;
  end

  assign ovf_set = word_done & fifo_full & ~out_if.i_ready;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      mode_q      <= MODE_VN;
      pair_have_q <= 1'b0;
      pair_bit_q  <= 1'b0;
      word_q      <= '0;
      idx_q       <= '0;
      run_q       <= '0;
      last_q      <= 1'b0;
      o_alarm     <= 1'b0;
      o_overflow  <= 1'b0;
    end else begin
      if (!i_en) begin
        mode_q      <= i_mode;
        pair_have_q <= 1'b0;
        pair_bit_q  <= 1'b0;
        word_q      <= '0;
        idx_q       <= '0;
        run_q       <= '0;
        last_q      <= 1'b0;
      end else begin
        run_q <= i_alarm_clr ? '0 : run_nxt;
        if (sample) last_q <= i_bit;
        if (rct_hit) begin
          pair_have_q <= 1'b0;
          word_q      <= '0;
          idx_q       <= '0;
        end else if (sample) begin
          if (mode_q == MODE_VN) begin
            pair_have_q <= ~pair_have_q;
            pair_bit_q  <= i_bit;
          end
          if (emit) begin
            if (word_done) begin
              word_q <= '0;
              idx_q  <= '0;
            end else begin
              word_q[idx_q] <= emit_bit;
              idx_q         <= idx_q + IDX_W'(1);
            end
          end
        end
      end
      if (i_alarm_clr) begin
        o_alarm    <= 1'b0;
        o_overflow <= 1'b0;
      end else begin
        if (rct_hit) o_alarm    <= 1'b1;
        if (ovf_set) o_overflow <= 1'b1;
      end
    end
  end

  assign out_if.o_valid = ~fifo_empty;

  trng_sync_fifo #(
    .W     (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (word_done),
    .i_data  (push_word),
    .i_pop   (out_if.i_ready),
    .o_data  (out_if.o_word),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_count (o_count)
  );
endmodule

// File: tb/tb_trng_vn_packer.sv
// Directed and randomized bench for trng_vn_packer (WORD_W=8, FIFO_DEPTH=4, RCT_CUTOFF=8).
module tb_trng_vn_packer;
  import trng_pkg::*;

  localparam int W = 8;
  localparam int D = 4;
  localparam int C = 8;

  logic       clk = 1'b0;
  logic       rst, en, mode, bit_in, bit_valid, ready, clr;
  logic [2:0] count;
  logic       ovf, alarm;

  trng_vn_packer_if #(.WORD_W(W)) bus ();
  assign bus.i_ready = ready;

  always #5 clk = ~clk;

  trng_vn_packer #(.WORD_W(W), .FIFO_DEPTH(D), .RCT_CUTOFF(C)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_en        (en),
    .i_mode      (mode),
    .i_bit       (bit_in),
    .i_bit_valid (bit_valid),
    .i_alarm_clr (clr),
    .out_if      (bus.master),
    .o_count     (count),
    .o_overflow  (ovf),
    .o_alarm     (alarm)
  );

  int    checks = 0;
  int    errors = 0;
  string cur_tag = "init";

  // Reference model: FIFO contents, pending emitted bits, pair half, run tracking.
  logic [W-1:0] exp_q[$];
  bit           m_bits[$];
  int           m_pair, m_run, m_last, m_mode, m_alarm, m_ovf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete(); m_bits.delete();
    m_pair = -1; m_run = 0; m_last = 0; m_mode = 0; m_alarm = 0; m_ovf = 0;
  endtask

  task automatic model_edge(input bit e, input bit v, input bit b, input bit r,
                            input bit cl, input bit md);
    bit accepted, hit, has_e, ebit, set_alarm, set_ovf;
    logic [W-1:0] w;
    accepted = e && v && (m_alarm == 0);
    hit = 0; has_e = 0; ebit = 0; set_alarm = 0; set_ovf = 0;
    if (r && exp_q.size() > 0) void'(exp_q.pop_front());
    if (!e) begin
      m_mode = md; m_pair = -1; m_bits.delete(); m_run = 0;
    end else if (accepted) begin
      if (!cl) begin
        if (m_run > 0 && b == m_last) m_run = (m_run < C) ? m_run + 1 : C;
        else m_run = 1;
        hit = (m_run == C);
      end
      m_last = b;
      if (hit) begin
        set_alarm = 1; m_pair = -1; m_bits.delete();
      end else begin
        if (m_mode == 1) begin has_e = 1; ebit = b; end
        else if (m_pair < 0) m_pair = b;
        else begin
          if (m_pair != b) begin has_e = 1; ebit = (m_pair == 1); end
          m_pair = -1;
        end
        if (has_e) begin
          m_bits.push_back(ebit);
          if (m_bits.size() == W) begin
            w = '0;
            for (int i = 0; i < W; i++) w[i] = m_bits[i];
            m_bits.delete();
            if (exp_q.size() < D) exp_q.push_back(w);
            else set_ovf = 1;
          end
        end
      end
    end
    if (e && cl) m_run = 0;
    if (cl) begin m_alarm = 0; m_ovf = 0; end
    else begin
      if (set_alarm) m_alarm = 1;
      if (set_ovf)   m_ovf = 1;
    end
  endtask

  task automatic chk_all();
    chk({cur_tag, "_valid"}, bus.o_valid, (exp_q.size() > 0) ? 1 : 0);
    chk({cur_tag, "_word"},  bus.o_word,  (exp_q.size() > 0) ? exp_q[0] : '0);
    chk({cur_tag, "_count"}, count, exp_q.size());
    chk({cur_tag, "_ovf"},   ovf, m_ovf);
    chk({cur_tag, "_alarm"}, alarm, m_alarm);
  endtask

  // Drive one clock with the given inputs, advance the model, then check all outputs.
  task automatic step(input bit e, input bit v, input bit b, input bit r, input bit cl);
    en = e; bit_valid = v; bit_in = b; ready = r; clr = cl;
    @(posedge clk);
    model_edge(e, v, b, r, cl, mode);
    #1;
    chk_all();
  endtask

  task automatic send_word(input logic [W-1:0] w, input bit r_body, input bit r_last);
    for (int i = 0; i < W; i++) step(1, 1, w[i], (i == W - 1) ? r_last : r_body, 0);
  endtask

  function automatic bit would_alarm(input logic [W-1:0] w);
    int r = m_run;
    int l = m_last;
    for (int i = 0; i < W; i++) begin
      if (r > 0 && w[i] == l) r++; else r = 1;
      l = w[i];
      if (r >= C) return 1;
    end
    return 0;
  endfunction

  function automatic logic [W-1:0] pick_word();
    logic [W-1:0] w;
    do w = W'($urandom_range(0, 255)); while (would_alarm(w));
    return w;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    #2;
    chk("rst_valid", bus.o_valid, 0);
    chk("rst_word", bus.o_word, 0);
    chk("rst_count", count, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_alarm", alarm, 0);
    @(posedge clk); #1;
    chk_all();
    rst = 1'b0;
  endtask

  task automatic drain();
    while (exp_q.size() > 0) step(1, 0, 0, 1, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] ws[5];
    logic [W-1:0] pat;
    bit           biased;
    rst = 0; en = 0; mode = 0; bit_in = 0; bit_valid = 0; ready = 0; clr = 0;
    model_reset();
    @(posedge clk); #1;
    cur_tag = "reset";
    do_reset();

    // Bypass packing of 1,1,0,0,1,0,1,1.
    cur_tag = "bypass_d3";
    mode = MODE_BYPASS; step(0, 0, 0, 0, 0);
    pat = 8'hD3;
    send_word(pat, 0, 0);
    chk("bypass_d3_word", bus.o_word, 8'hD3);
    chk("bypass_d3_count", count, 1);
    chk("bypass_d3_alarm", alarm, 0);
    drain();
    chk("bypass_d3_drained", count, 0);

    // Von Neumann: pairs 10,01 four times -> one word 8'h55.
    cur_tag = "vn_55";
    mode = MODE_VN; step(0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      step(1, 1, (i % 4 == 0 || i % 4 == 3), 0, 0);
      if (i == 14) chk("vn_valid_before_16th", bus.o_valid, 0);
    end
    chk("vn_valid_after_16th", bus.o_valid, 1);
    chk("vn_word_55", bus.o_word, 8'h55);
    chk("vn_count_1", count, 1);
    drain();

    // Overflow: five words with consumer stalled, then ordered drain.
    cur_tag = "overflow";
    mode = MODE_BYPASS; step(0, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      ws[k] = pick_word();
      send_word(ws[k], 0, 0);
      chk("ovf_head_stable", bus.o_word, ws[0]);
    end
    chk("ovf_count_4", count, 4);
    chk("ovf_flag", ovf, 1);
    for (int k = 0; k < 4; k++) begin
      chk("ovf_drain_order", bus.o_word, ws[k]);
      step(1, 0, 0, 1, 0);
    end
    chk("ovf_drained", count, 0);
    step(1, 0, 0, 0, 1);
    chk("ovf_cleared", ovf, 0);

    // Full buffer with simultaneous pop and push.
    cur_tag = "pop_push";
    for (int k = 0; k < 4; k++) send_word(pick_word(), 0, 0);
    chk("pp_full", count, 4);
    send_word(pick_word(), 0, 1);
    chk("pp_count_4", count, 4);
    chk("pp_no_ovf", ovf, 0);
    drain();

    // Repetition-count alarm and recovery.
    cur_tag = "rct";
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      step(1, 1, 1, 0, 0);
      if (i == 6) chk("rct_alarm_before", alarm, 0);
    end
    chk("rct_alarm_set", alarm, 1);
    chk("rct_no_push", count, 0);
    for (int i = 0; i < 3; i++) step(1, 1, i[0], 0, 0);
    step(1, 0, 0, 0, 1);
    chk("rct_alarm_clr", alarm, 0);
    send_word(8'h3C, 0, 0);
    chk("rct_resume_word", bus.o_word, 8'h3C);
    chk("rct_resume_count", count, 1);
    drain();

    // Reset mid-word loses partial data.
    cur_tag = "midreset";
    step(1, 1, 1, 0, 0); step(1, 1, 0, 0, 0); step(1, 1, 1, 0, 0);
    do_reset();
    mode = MODE_BYPASS; step(0, 0, 0, 0, 0);
    send_word(8'hA5, 0, 0);
    chk("midreset_word_a5", bus.o_word, 8'hA5);
    chk("midreset_count", count, 1);
    drain();

    // Randomized traffic: mode flips, enable drops, biased bits, slow consumer, clears.
    cur_tag = "random";
    biased = 0;
    for (int n = 0; n < 600; n++) begin
      if (n % 100 == 0) biased = ~biased;
      mode = $urandom_range(0, 1);
      step($urandom_range(0, 19) != 0,
           $urandom_range(0, 3) != 0,
           biased ? ($urandom_range(0, 9) != 0) : $urandom_range(0, 1),
           $urandom_range(0, 2) == 0,
           $urandom_range(0, 39) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
